// File: rtl/sprite_processor_if.sv
// sprite_processor_if: instruction-load and debug/observation bundle for sprite_processor
interface sprite_processor_if #(
   parameter int PCW = 5
);
   logic           imem_we_in;
   logic [PCW-1:0] imem_addr_in;
   logic [35:0]    imem_data_in;
   logic [3:0]     dbg_reg_sel_in;
   logic [31:0]    dbg_reg_out;
   logic [7:0]     dbg_spr_sel_in;
   logic [1:0]     dbg_fld_sel_in;
   logic [31:0]    dbg_spr_out;
   logic [PCW-1:0] pc_out;
   logic           halted_out;
   modport master (
      output imem_we_in, imem_addr_in, imem_data_in, dbg_reg_sel_in, dbg_spr_sel_in, dbg_fld_sel_in,
      input  dbg_reg_out, dbg_spr_out, pc_out, halted_out
   );
   modport slave (
      input  imem_we_in, imem_addr_in, imem_data_in, dbg_reg_sel_in, dbg_spr_sel_in, dbg_fld_sel_in,
      output dbg_reg_out, dbg_spr_out, pc_out, halted_out
   );
endinterface

// File: rtl/sprite_processor.sv
// sprite_processor: multi-cycle in-order processor maintaining the sprite table
module sprite_processor #(
   parameter int INSTRUCTIONS_SIZE = 20,
   parameter int MAX_SPRITES       = 2,
   parameter int MEMORY_SIZE       = 256,
   parameter int INSTRUCTION_WIDTH = 36,
   parameter int ROW_SIZE          = 1720
) (
   input logic               pixel_clk_in,
   input logic               rst_in,
   sprite_processor_if.slave bus
);
   localparam int PCW = $clog2(INSTRUCTIONS_SIZE);
   localparam int AW  = $clog2(MEMORY_SIZE);
   localparam int SW  = MAX_SPRITES > 1 ? $clog2(MAX_SPRITES) : 1;
   localparam logic [PCW:0] ISZ = (PCW+1)'(INSTRUCTIONS_SIZE);

   typedef enum logic [2:0] {FETCH, EXEC, MEMWAIT, WB, HALT} state_t;

   state_t                       state_q, state_d;
   logic [PCW-1:0]               pc_q, pc_d, pc_inc, tgt;
   logic [INSTRUCTION_WIDTH-1:0] ir_q, ir_d;
   logic [INSTRUCTION_WIDTH-1:0] imem [INSTRUCTIONS_SIZE];
   logic [31:0]                  dmem [MEMORY_SIZE];
   logic [31:0]                  regs_q [16];
   logic [31:0]                  regs_d [16];
   logic [31:0]                  spr_q [MAX_SPRITES][4];
   logic [31:0]                  spr_d [MAX_SPRITES][4];
   logic [31:0]                  rdata1_q, rdata2_q;
   logic [3:0]                   op, rd, rs1, rs2;
   logic [19:0]                  imm;
   logic [31:0]                  simm, a, b, res;
   logic [AW-1:0]                mem_addr;
   logic                         mem_we, wr_en, spr_ok, dbg_ok;

   assign op       = ir_q[35:32];
   assign rd       = ir_q[31:28];
   assign rs1      = ir_q[27:24];
   assign rs2      = ir_q[23:20];
   assign imm      = ir_q[19:0];
   assign simm     = {{12{imm[19]}}, imm};
   assign a        = regs_q[rs1];
   assign b        = regs_q[rs2];
   assign tgt      = imm[PCW-1:0];
   assign pc_inc   = pc_q + PCW'(1);
   assign mem_addr = AW'(a + simm);
   assign spr_ok   = a < 32'(MAX_SPRITES);
   assign dbg_ok   = {24'd0, bus.dbg_spr_sel_in} < 32'(MAX_SPRITES);

   assign bus.dbg_reg_out = regs_q[bus.dbg_reg_sel_in];
   assign bus.dbg_spr_out = dbg_ok ? spr_q[bus.dbg_spr_sel_in[SW-1:0]][bus.dbg_fld_sel_in] : 32'd0;
   assign bus.pc_out      = pc_q;
   assign bus.halted_out  = state_q == HALT || (state_q == EXEC && op == 4'hF);

   // sequencing, decode/execute and architectural next-state
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      regs_d  = regs_q;
      spr_d   = spr_q;
      ir_d    = state_q == FETCH ? imem[pc_q] : ir_q;
      mem_we  = 1'b0;
      wr_en   = 1'b0;
      res     = 32'd0;
      case (state_q)
         FETCH: state_d = EXEC;
         EXEC: begin
            pc_d = pc_inc;
            case (op)
               4'h1: begin wr_en = 1'b1; res = simm; end
               4'h2: begin wr_en = 1'b1; res = a + b; end
               4'h3: begin wr_en = 1'b1; res = a - b; end
               4'h4: begin wr_en = 1'b1; res = a + simm; end
               4'h5: pc_d = pc_q;
               4'h6: mem_we = rst_in;
               4'h7: pc_d = a == b ? tgt : pc_inc;
               4'h8: pc_d = $signed(a) < $signed(b) ? tgt : pc_inc;
               4'h9: pc_d = tgt;
               4'hA: if (spr_ok) spr_d[a[SW-1:0]][imm[1:0]] = b;
               4'hB: begin wr_en = 1'b1; res = spr_ok ? spr_q[a[SW-1:0]][imm[1:0]] : 32'd0; end
               4'hC: begin wr_en = 1'b1; res = a * 32'(ROW_SIZE) + b; end
               4'hF: pc_d = pc_q;
               default: ;
            endcase
            state_d = op == 4'h5 ? MEMWAIT : op == 4'hF ? HALT : {1'b0, pc_d} >= ISZ ? HALT : FETCH;
         end
         MEMWAIT: state_d = WB;
         WB: begin
            wr_en   = 1'b1;
            res     = rdata2_q;
            pc_d    = pc_inc;
            state_d = {1'b0, pc_d} >= ISZ ? HALT : FETCH;
         end
         default: ;
      endcase
      if (wr_en && rd != 4'd0) regs_d[rd] = res;
   end

   // architectural state with synchronous active-low reset
   always_ff @(posedge pixel_clk_in) begin
      ir_q <= ir_d;
      if (!rst_in) begin
         state_q <= FETCH;
         pc_q    <= '0;
         regs_q  <= '{default: '0};
         spr_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         regs_q  <= regs_d;
         spr_q   <= spr_d;
      end
   end

   // instruction and data memories, retained across reset; data read is a 2-stage pipeline
   always_ff @(posedge pixel_clk_in) begin
      if (bus.imem_we_in) imem[bus.imem_addr_in] <= bus.imem_data_in;
      if (mem_we) dmem[mem_addr] <= b;
      rdata1_q <= dmem[mem_addr];
      rdata2_q <= rdata1_q;
   end
endmodule

// File: tb/tb_sprite_processor.sv
// tb_sprite_processor: directed and random programs checked against an instruction-level model
module tb_sprite_processor;
   bit   clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sprite_processor_if #(.PCW(5)) ifc ();
   sprite_processor dut (.pixel_clk_in(clk), .rst_in(rst), .bus(ifc));

   int          n_asserts = 0;
   int          n_fail = 0;
   logic [35:0] prog [20];
   logic [31:0] m_regs [16];
   logic [31:0] m_spr [2][4];
   logic [31:0] m_mem [256];
   int          m_pc, m_edges, edges;
   logic [31:0] v;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] ins(input int op, input int rd, input int rs1, input int rs2, input int imm);
      return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[19:0]};
   endfunction

   task automatic clear_prog();
      for (int i = 0; i < 20; i++) prog[i] = ins(15, 0, 0, 0, 0);
   endtask

   task automatic model_clear();
      m_regs = '{default: '0};
      m_spr  = '{default: '0};
      m_pc   = 0;
      m_edges = 0;
   endtask

   // architectural interpreter: one loop iteration per instruction
   task automatic model_run();
      logic [35:0] w;
      logic [31:0] a, b, simm, res;
      logic [19:0] imm;
      int op, rd, nxt;
      bit wr;
      model_clear();
      for (int step = 0; step < 100000; step++) begin
         w    = prog[m_pc];
         op   = int'(w[35:32]);
         rd   = int'(w[31:28]);
         a    = m_regs[w[27:24]];
         b    = m_regs[w[23:20]];
         imm  = w[19:0];
         simm = {{12{imm[19]}}, imm};
         if (op == 15) begin
            m_edges += 1;
            break;
         end
         m_edges += op == 5 ? 4 : 2;
         nxt = m_pc + 1;
         wr  = 1'b0;
         res = 32'd0;
         case (op)
            1: begin wr = 1'b1; res = simm; end
            2: begin wr = 1'b1; res = a + b; end
            3: begin wr = 1'b1; res = a - b; end
            4: begin wr = 1'b1; res = a + simm; end
            5: begin wr = 1'b1; res = m_mem[(a + simm) % 256]; end
            6: m_mem[(a + simm) % 256] = b;
            7: if (a == b) nxt = int'(imm) % 32;
            8: if ($signed(a) < $signed(b)) nxt = int'(imm) % 32;
            9: nxt = int'(imm) % 32;
            10: if (a < 2) m_spr[a][imm % 4] = b;
            11: begin wr = 1'b1; res = a < 2 ? m_spr[a][imm % 4] : 32'd0; end
            12: begin wr = 1'b1; res = a * 1720 + b; end
            default: ;
         endcase
         if (wr && rd != 0) m_regs[rd] = res;
         m_pc = nxt;
         if (m_pc >= 20) break;
      end
   endtask

   task automatic load_prog();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         ifc.imem_we_in   = 1'b1;
         ifc.imem_addr_in = i[4:0];
         ifc.imem_data_in = prog[i];
      end
      @(negedge clk);
      ifc.imem_we_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_dut(input int budget, output int e);
      e = -1;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk);
         #1;
         if (ifc.halted_out) begin
            e = i;
            break;
         end
      end
   endtask

   task automatic rreg(input int r, output logic [31:0] val);
      ifc.dbg_reg_sel_in = r[3:0];
      #1;
      val = ifc.dbg_reg_out;
   endtask

   task automatic check_state(input string tag);
      for (int r = 0; r < 16; r++) begin
         ifc.dbg_reg_sel_in = r[3:0];
         #1;
         chk($sformatf("%s r%0d", tag, r), ifc.dbg_reg_out, m_regs[r]);
      end
      for (int s = 0; s < 3; s++)
         for (int f = 0; f < 4; f++) begin
            ifc.dbg_spr_sel_in = s[7:0];
            ifc.dbg_fld_sel_in = f[1:0];
            #1;
            chk($sformatf("%s spr%0d.%0d", tag, s, f), ifc.dbg_spr_out, s < 2 ? m_spr[s][f] : 32'd0);
         end
      chk({tag, " pc"}, {27'd0, ifc.pc_out}, m_pc);
   endtask

   task automatic run_and_check(input string tag, input int budget);
      model_run();
      run_dut(budget, edges);
      chk({tag, " halt edge"}, edges, m_edges);
      check_state(tag);
   endtask

   initial begin
      int op, imm;
      ifc.imem_we_in = 1'b0;
      ifc.imem_addr_in = '0;
      ifc.imem_data_in = '0;
      ifc.dbg_reg_sel_in = '0;
      ifc.dbg_spr_sel_in = '0;
      ifc.dbg_fld_sel_in = '0;

      // fill data memory with mem[i]=i using a BLT loop
      clear_prog();
      prog[0] = ins(6, 0, 1, 1, 0);
      prog[1] = ins(4, 1, 1, 0, 1);
      prog[2] = ins(1, 2, 0, 0, 256);
      prog[3] = ins(8, 0, 1, 2, 0);
      load_prog();
      model_clear();
      check_state("reset");
      chk("reset halted", ifc.halted_out, 1'b0);
      run_and_check("meminit", 5000);

      // LI/LI/ADD/HALT with exact halt timing and frozen pc
      clear_prog();
      prog[0] = ins(1, 1, 0, 0, 5);
      prog[1] = ins(1, 2, 0, 0, 7);
      prog[2] = ins(2, 3, 1, 2, 0);
      load_prog();
      run_and_check("add", 50);
      chk("add edge7", edges, 7);
      rreg(3, v);
      chk("add r3", v, 32'd12);
      repeat (5) @(posedge clk);
      #1;
      chk("frozen pc", {27'd0, ifc.pc_out}, 32'd3);
      chk("frozen halted", ifc.halted_out, 1'b1);

      // store/load round trip and address aliasing past MEMORY_SIZE
      clear_prog();
      prog[0] = ins(1, 1, 0, 0, 32'h1234);
      prog[1] = ins(6, 0, 0, 1, 0);
      prog[2] = ins(5, 4, 0, 0, 0);
      prog[3] = ins(1, 2, 0, 0, 32'hABCD);
      prog[4] = ins(6, 0, 0, 2, 257);
      prog[5] = ins(5, 5, 0, 0, 1);
      load_prog();
      run_and_check("ldst", 100);
      chk("ldst edges", edges, 17);
      rreg(4, v);
      chk("ldst r4", v, 32'h1234);
      rreg(5, v);
      chk("alias r5", v, 32'hABCD);

      // sprite write/read, in range and out of range
      clear_prog();
      prog[0] = ins(1, 1, 0, 0, 1);
      prog[1] = ins(1, 2, 0, 0, 100);
      prog[2] = ins(10, 0, 1, 2, 0);
      prog[3] = ins(11, 5, 1, 0, 0);
      prog[4] = ins(1, 1, 0, 0, 2);
      prog[5] = ins(1, 3, 0, 0, 55);
      prog[6] = ins(10, 0, 1, 3, 1);
      prog[7] = ins(11, 6, 1, 0, 0);
      load_prog();
      run_and_check("sprite", 100);
      rreg(5, v);
      chk("spr r5", v, 32'd100);
      ifc.dbg_spr_sel_in = 8'd1;
      ifc.dbg_fld_sel_in = 2'd0;
      #1;
      chk("dbg spr1.x", ifc.dbg_spr_out, 32'd100);

      // PIX, wrap-around, r0 immutability, SUB
      clear_prog();
      prog[0] = ins(1, 1, 0, 0, 3);
      prog[1] = ins(1, 2, 0, 0, 10);
      prog[2] = ins(12, 6, 1, 2, 0);
      prog[3] = ins(1, 7, 0, 0, -1);
      prog[4] = ins(1, 8, 0, 0, -1);
      prog[5] = ins(4, 8, 8, 0, 1);
      prog[6] = ins(1, 0, 0, 0, 9);
      prog[7] = ins(3, 9, 1, 2, 0);
      load_prog();
      run_and_check("arith", 100);
      rreg(6, v);
      chk("pix r6", v, 32'd5170);
      rreg(7, v);
      chk("li r7", v, 32'hFFFFFFFF);
      rreg(8, v);
      chk("wrap r8", v, 32'd0);

      // countdown loop
      clear_prog();
      prog[0] = ins(1, 1, 0, 0, 3);
      prog[1] = ins(4, 1, 1, 0, -1);
      prog[2] = ins(4, 3, 3, 0, 1);
      prog[3] = ins(8, 0, 0, 1, 1);
      load_prog();
      run_and_check("loop", 200);
      rreg(1, v);
      chk("loop r1", v, 32'd0);
      rreg(3, v);
      chk("loop iters", v, 32'd3);

      // all-NOP program runs off the end of instruction memory
      for (int i = 0; i < 20; i++) prog[i] = ins(0, 0, 0, 0, 0);
      load_prog();
      run_and_check("nops", 200);
      chk("nops pc20", {27'd0, ifc.pc_out}, 32'd20);

      // reset on the LD writeback edge aborts it; rerun gives the same result
      clear_prog();
      prog[0] = ins(1, 1, 0, 0, 32'h5A5A);
      prog[1] = ins(6, 0, 0, 1, 5);
      prog[2] = ins(5, 4, 0, 0, 5);
      load_prog();
      @(negedge clk);
      rst = 1'b1;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      model_clear();
      check_state("midrst");
      chk("midrst halted", ifc.halted_out, 1'b0);
      run_and_check("rerun", 50);
      rreg(4, v);
      chk("rerun r4", v, 32'h5A5A);

      // random forward-branching programs
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 20; i++) begin
            op = int'($urandom_range(0, 15));
            if (op == 15 && $urandom_range(0, 3) != 0) op = 1;
            imm = $urandom_range(0, 1) != 0 ? int'($urandom_range(0, 7)) : int'($urandom);
            if (op >= 7 && op <= 9) imm = int'($urandom & 32'hFFFE0) | int'($urandom_range(i + 1, 31));
            prog[i] = ins(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), imm);
         end
         load_prog();
         run_and_check($sformatf("rand%0d", k), 300);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end
endmodule
